// File: rtl/tio_wb_watchdog.sv
// ---------------------------------------------------------------------------
// tio_wb_watchdog
//
// This module watches the Wishbone path between the TURFIO register master
// and the register targets. Each request passes through one registered
// stage. The watchdog returns a Wishbone error to the master in two cases:
//   - the target does not respond within TIMEOUT cycles, or
//   - the target's clock domain is flagged as dead. In this case the request
//     is never forwarded.
// A dead target therefore cannot hang the register bus. Every error the
// watchdog generates is counted, and its address is captured so that
// housekeeping can read it out.
//
// Ports
//   wb_clk_i, wb_rst_n_i       clock; synchronous active-low reset
//   wbs_*                      upstream slave side (from the master);
//                              wbs_rty_o is always 0
//   target_clk_ok_i            clock-running flag for the addressed target
//   wbm_*                      downstream master side (to the targets)
//   timeout_count_o            saturating count of watchdog-generated errors
//   last_timeout_adr_o         address of the most recent such error
//   clear_stats_i              one-cycle pulse that zeroes both statistics
// ---------------------------------------------------------------------------
module tio_wb_watchdog #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'h4241_4443
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [11:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o,
  output logic [31:0] wbs_dat_o,
  input  logic        target_clk_ok_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [11:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic [31:0] wbm_dat_i,
  output logic [7:0]  timeout_count_o,
  output logic [11:0] last_timeout_adr_o,
  input  logic        clear_stats_i
);

  // The counter starts at 0 in the first strobed cycle. When it holds
  // CNT_LAST, the strobe has been high for exactly TIMEOUT cycles.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FWD, RESP, DRAIN} state_t;

  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic        ack_reg;
  logic        err_reg;
  logic [31:0] sdat_reg;
  logic        mcyc_reg;
  logic        mstb_reg;
  logic        mwe_reg;
  logic [11:0] madr_reg;
  logic [31:0] mdat_reg;
  logic [7:0]  tcnt_reg;
  logic [11:0] tadr_reg;

  logic        req;
  logic        dead_hit;
  logic        tmo_hit;
  logic        stat_hit;
  logic [11:0] stat_adr;

  assign req = wbs_cyc_i & wbs_stb_i;

  // These are the only two events that count as watchdog errors. A target
  // response in the final cycle takes priority over the timeout, so that
  // cycle does not count. A master abort also takes priority over everything.
  assign dead_hit = (state_reg == IDLE) && req && !target_clk_ok_i;
  assign tmo_hit  = (state_reg == FWD) && wbs_cyc_i && !wbm_ack_i && !wbm_err_i
                    && (cnt_reg == CNT_LAST);
  assign stat_hit = dead_hit | tmo_hit;
  assign stat_adr = dead_hit ? wbs_adr_i : madr_reg;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      sdat_reg  <= '0;
      mcyc_reg  <= 1'b0;
      mstb_reg  <= 1'b0;
      mwe_reg   <= 1'b0;
      madr_reg  <= '0;
      mdat_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // In IDLE, wbm_ack_i and wbm_err_i are deliberately ignored. They
          // can only be late responses to an aborted or timed-out request.
          if (req) begin
            if (!target_clk_ok_i) begin
              err_reg   <= 1'b1;
              sdat_reg  <= ERR_DATA;
              state_reg <= RESP;
            end else begin
              madr_reg  <= wbs_adr_i;
              mdat_reg  <= wbs_dat_i;
              mwe_reg   <= wbs_we_i;
              mcyc_reg  <= 1'b1;
              mstb_reg  <= 1'b1;
              cnt_reg   <= '0;
              state_reg <= FWD;
            end
          end
        end

        FWD: begin
          if (!wbs_cyc_i) begin
            // The master abandoned the cycle. Drop the request and send
            // no response upstream.
            mcyc_reg  <= 1'b0;
            mstb_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (wbm_ack_i) begin
            ack_reg   <= 1'b1;
            sdat_reg  <= wbm_dat_i;
            mcyc_reg  <= 1'b0;
            mstb_reg  <= 1'b0;
            state_reg <= RESP;
          end else if (wbm_err_i) begin
            err_reg   <= 1'b1;
            sdat_reg  <= wbm_dat_i;
            mcyc_reg  <= 1'b0;
            mstb_reg  <= 1'b0;
            state_reg <= RESP;
          end else if (cnt_reg == CNT_LAST) begin
            err_reg   <= 1'b1;
            sdat_reg  <= ERR_DATA;
            mcyc_reg  <= 1'b0;
            mstb_reg  <= 1'b0;
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end

        RESP: begin
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
          state_reg <= DRAIN;
        end

        DRAIN: begin
          // Wait here until the strobe drops. This stops a strobe that is
          // held high from being taken as a second request.
          if (!wbs_stb_i) begin
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // Statistics. A clear overrides an increment that happens in the same cycle.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i || clear_stats_i) begin
      tcnt_reg <= '0;
      tadr_reg <= '0;
    end else if (stat_hit) begin
      if (tcnt_reg != 8'hFF) begin
        tcnt_reg <= tcnt_reg + 8'd1;
      end
      tadr_reg <= stat_adr;
    end
  end

  assign wbs_ack_o          = ack_reg;
  assign wbs_err_o          = err_reg;
  assign wbs_rty_o          = 1'b0;
  assign wbs_dat_o          = sdat_reg;
  assign wbm_cyc_o          = mcyc_reg;
  assign wbm_stb_o          = mstb_reg;
  assign wbm_we_o           = mwe_reg;
  assign wbm_adr_o          = madr_reg;
  assign wbm_dat_o          = mdat_reg;
  assign timeout_count_o    = tcnt_reg;
  assign last_timeout_adr_o = tadr_reg;

endmodule
